mm_result_writer: RTL and testbench



---
 rtl/mm_result_writer.sv | 145 ++++++++++++++
 tb/tb_mm_result_writer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_result_writer.sv
// Result writer: buffers signed result elements in a small FIFO and writes each one to the
// result memory as a low word then a high word. Define MM_SAT_EN for single-word saturated writes.
module mm_result_writer #(
  parameter int                DATA_W     = 40,
  parameter int                WORD_W     = 20,
  parameter int                ADDR_W     = 20,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_finish,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  output logic [19:0]       elem_cnt,
  output logic              done,
  output logic              overflow
);

  localparam int             PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WR_LO = 2'd1;
  localparam logic [1:0] WR_HI = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [19:0]       elem_cnt_q, elem_cnt_d;
  logic              fin_q, fin_d, ovf_q, ovf_d;
  logic              fifo_full, fifo_empty, active, push, pop;
  logic [WORD_W-1:0] lo_word;

  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign active     = (state_q != DONE);
  assign in_ready   = active && !fifo_full;
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == IDLE) && !fifo_empty;

`ifdef MM_SAT_EN
  // Fits in WORD_W signed bits only when all bits from the word's sign bit upward agree.
  always_comb begin
    lo_word = hold_q[WORD_W-1:0];
    if (!(&hold_q[DATA_W-1:WORD_W-1]) && (|hold_q[DATA_W-1:WORD_W-1]))
      lo_word = hold_q[DATA_W-1] ? {1'b1, {(WORD_W-1){1'b0}}} : {1'b0, {(WORD_W-1){1'b1}}};
  end
`else
  assign lo_word = hold_q[WORD_W-1:0];
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    elem_cnt_d = elem_cnt_q;
    wr_idx_d   = push ? wr_idx_q + 1'b1 : wr_idx_q;
    rd_idx_d   = pop  ? rd_idx_q + 1'b1 : rd_idx_q;
    fin_d      = fin_q | (in_finish && active);
    ovf_d      = ovf_q | (in_valid && fifo_full && active);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    case (state_q)
      IDLE: begin
        if (!fifo_empty)  state_d = WR_LO;
        else if (fin_q)   state_d = DONE;
      end
      WR_LO: begin
        if (mem_gnt) begin
          ptr_d = ptr_q + 1'b1;
`ifdef MM_SAT_EN
          elem_cnt_d = elem_cnt_q + 1'b1;
          state_d    = IDLE;
`else
          state_d    = WR_HI;
`endif
        end
      end
      WR_HI: begin
        if (mem_gnt) begin
          ptr_d      = ptr_q + 1'b1;
          elem_cnt_d = elem_cnt_q + 1'b1;
          state_d    = IDLE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_wdata = '0;
    if (state_q == WR_LO)      mem_wdata = lo_word;
    else if (state_q == WR_HI) mem_wdata = hold_q[DATA_W-1:WORD_W];
  end

  assign mem_we   = (state_q == WR_LO) || (state_q == WR_HI);
  assign mem_addr = ptr_q;
  assign elem_cnt = elem_cnt_q;
  assign done     = (state_q == DONE);
  assign overflow = ovf_q;

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= BASE_ADDR;
      elem_cnt_q <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      cnt_q      <= '0;
      fin_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      elem_cnt_q <= elem_cnt_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      cnt_q      <= cnt_d;
      fin_q      <= fin_d;
      ovf_q      <= ovf_d;
    end
  end

  // NOTE: FIFO storage and the hold register have no reset; they are only read after a push/pop.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_idx_q] <= in_data;
    if (pop)  hold_q <= fifo_mem_q[rd_idx_q];
  end

endmodule

// File: tb/tb_mm_result_writer.sv
// Self-checking bench for mm_result_writer: directed cases plus randomized traffic
// scored against a queue model of the expected memory write stream.
module tb_mm_result_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [39:0] in_data;
  logic        in_finish;
  logic        in_ready;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [19:0] mem_wdata;
  logic        mem_gnt;
  logic [19:0] elem_cnt;
  logic        done;
  logic        overflow;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          rand_gnt = 1'b0;

  logic [19:0] obs_addr[$], obs_data[$];
  logic [19:0] exp_addr[$], exp_data[$];
  logic [19:0] exp_ptr;
  logic [19:0] n_acc;

  mm_result_writer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_finish(in_finish),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .elem_cnt(elem_cnt), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Write monitor: a write lands on the rising edge where mem_we and mem_gnt are both high.
  always @(negedge clk) begin
    if (!reset && mem_we && mem_gnt) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_gnt) mem_gnt = ($urandom_range(0, 3) != 0);
  endtask

  function automatic void model_clear();
    obs_addr.delete(); obs_data.delete();
    exp_addr.delete(); exp_data.delete();
    exp_ptr = 20'd0;
    n_acc   = 20'd0;
  endfunction

  // Expected memory traffic for one accepted element.
  function automatic void model_push(input logic [39:0] d);
    logic signed [39:0] v;
    logic [19:0]        w;
    v = d;
`ifdef MM_SAT_EN
    if (v > 40'sd524287)       w = 20'h7FFFF;
    else if (v < -40'sd524288) w = 20'h80000;
    else                       w = v % 40'sd1048576 < 0 ? 20'(v + 40'sd1048576) : 20'(v);
    exp_addr.push_back(exp_ptr); exp_data.push_back(w); exp_ptr++;
`else
    w = 20'(d % 40'd1048576);
    exp_addr.push_back(exp_ptr); exp_data.push_back(w); exp_ptr++;
    w = 20'(d / 40'd1048576);
    exp_addr.push_back(exp_ptr); exp_data.push_back(w); exp_ptr++;
`endif
    n_acc++;
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_finish = 1'b0; in_data = '0;
    step();
    reset = 1'b0;
    model_clear();
  endtask

  // Well-behaved producer: only raises in_valid once in_ready is seen.
  task automatic push_elem(input logic [39:0] d, input bit fin);
    int t = 0;
    in_valid = 1'b0;
    while (!in_ready && t < 500) begin step(); t++; end
    if (!in_ready) check("push_ready_timeout", in_ready, 1);
    else begin
      in_valid = 1'b1; in_data = d; in_finish = fin;
      step();
      in_valid = 1'b0; in_finish = 1'b0;
      model_push(d);
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_write_count"}, obs_addr.size(), exp_addr.size());
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
    end
    obs_addr.delete(); obs_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (elem_cnt != n_acc && t < 2000) begin step(); t++; end
    check({tag, "_elem_cnt"}, elem_cnt, n_acc);
    step();
    compare_writes(tag);
  endtask

  initial begin
    logic [39:0] d;
    int          t;
    mem_gnt = 1'b1;
    do_reset();

    // Reset state
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_elem_cnt", elem_cnt, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_in_ready", in_ready, 1);

    // Single element with finish in the same cycle; cycle-exact latency and done timing
    in_valid = 1'b1; in_data = 40'h00000_00007; in_finish = 1'b1;
    step();
    in_valid = 1'b0; in_finish = 1'b0;
    model_push(40'h00000_00007);
    check("lat_pop_we", mem_we, 0);
    step();
    check("lat_lo_we", mem_we, 1);
    check("lat_lo_addr", mem_addr, 0);
    check("lat_lo_data", mem_wdata, 20'h00007);
    step();
`ifndef MM_SAT_EN
    check("lat_hi_we", mem_we, 1);
    check("lat_hi_addr", mem_addr, 1);
    check("lat_hi_data", mem_wdata, 20'h00000);
    step();
`endif
    check("single_elem_cnt", elem_cnt, 1);
    check("single_done_early", done, 0);
    step();
    check("single_done", done, 1);
    check("single_we_off", mem_we, 0);
    check("done_in_ready", in_ready, 0);
    in_valid = 1'b1; in_finish = 1'b1;
    step();
    in_valid = 1'b0; in_finish = 1'b0;
    check("done_ignores_valid_ovf", overflow, 0);
    check("done_sticky", done, 1);
    compare_writes("single");

    // Negative value
    do_reset();
    push_elem(40'hFFFFFFFFFA, 1'b0);
    drain("neg");

    // Stall in WR_LO: outputs must hold steady while mem_gnt is low
    do_reset();
    mem_gnt = 1'b0;
    push_elem(40'h12345_6789A, 1'b0);
    t = 0;
    while (!mem_we && t < 10) begin step(); t++; end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_we%0d", i), mem_we, 1);
      check($sformatf("stall_addr%0d", i), mem_addr, exp_addr[0]);
      check($sformatf("stall_data%0d", i), mem_wdata, exp_data[0]);
      step();
    end
    mem_gnt = 1'b1;
    drain("stall");

    // Overflow with mem_gnt low: element 1 moves to the hold register, 2..5 fill the FIFO,
    // so element 6 is the one dropped.
    do_reset();
    mem_gnt = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) check($sformatf("ovf_ready%0d", i), in_ready, 1);
      in_valid = 1'b1; in_data = 40'(i);
      step();
      if (i <= 5) model_push(40'(i));
      if (i == 5) begin
        check("ovf_full_ready", in_ready, 0);
        check("ovf_not_yet", overflow, 0);
      end
    end
    in_valid = 1'b0;
    check("ovf_set", overflow, 1);
    step();
    check("ovf_sticky", overflow, 1);
    mem_gnt = 1'b1;
    drain("ovf");
    check("ovf_after_drain", overflow, 1);

    // Reset in the middle of an element write
    do_reset();
    push_elem(40'hABCDE_12345, 1'b0);
    step();
`ifndef MM_SAT_EN
    step();
    check("midrst_in_hi", mem_addr, 1);
`endif
    check("midrst_writing", mem_we, 1);
    reset = 1'b1;
    step();
    check("midrst_we", mem_we, 0);
    check("midrst_elem_cnt", elem_cnt, 0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_wdata", mem_wdata, 0);
    reset = 1'b0;
    model_clear();
    push_elem(40'h0000F_0000E, 1'b0);
    drain("midrst");

`ifdef MM_SAT_EN
    do_reset();
    push_elem(40'd600000, 1'b0);
    push_elem(-40'sd600000, 1'b0);
    drain("sat");
`endif

    // Randomized traffic with random grants, finish on the last element
    do_reset();
    rand_gnt = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) step();
      if ($urandom_range(0, 2) == 0) d = 40'($signed(20'($urandom)));
      else                           d = {8'($urandom), 32'($urandom)};
      push_elem(d, i == 39);
    end
    t = 0;
    while (!done && t < 3000) begin step(); t++; end
    rand_gnt = 1'b0;
    mem_gnt = 1'b1;
    check("rand_done", done, 1);
    check("rand_elem_cnt", elem_cnt, n_acc);
    check("rand_overflow", overflow, 0);
    compare_writes("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
